// File: rtl/counter_sched.sv
// counter_sched: shares one external up/down counter between two requesters.
// The winner of a round-robin arbitration gets the counter cleared, then
// enabled until it reaches the target value, and finally receives a done pulse.
module counter_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] steps_a,
  input  logic             dir_a,
  output logic             gnt_a,
  output logic             done_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] steps_b,
  input  logic             dir_b,
  output logic             gnt_b,
  output logic             done_b,
  output logic             cnt_rst,
  output logic             cnt_enable,
  output logic             cnt_direction,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    CLEAR = 4'b0010,
    RUN   = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  state_t           state_r, state_s;
  logic             owner_r, owner_s;
  logic             last_r;
  logic             dir_r, dir_s;
  logic [WIDTH-1:0] term_r, term_s;
  logic [WIDTH-1:0] steps_sel_s;
  logic             owner_req_s;
  logic             at_term_s;
  logic             gnt_a_r, gnt_b_r, done_a_r, done_b_r;
  logic             busy_r, cnt_rst_r, cnt_dir_r;

  // Request line of whoever currently owns the counter (drop means abort).
  always_comb begin
    owner_req_s = 1'b0;
    if (owner_r == OWN_B) begin
      owner_req_s = req_b;
    end else begin
      owner_req_s = req_a;
    end
  end

  assign at_term_s = (cnt_value == term_r);

  // Next-state logic, arbitration and latching of the winner's run parameters.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    dir_s       = dir_r;
    term_s      = term_r;
    steps_sel_s = {WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (req_a || req_b) begin
          if (req_a && req_b) begin
            owner_s = ~last_r;
          end else if (req_b) begin
            owner_s = OWN_B;
          end else begin
            owner_s = OWN_A;
          end
          if (owner_s == OWN_B) begin
            steps_sel_s = steps_b;
            dir_s       = dir_b;
          end else begin
            steps_sel_s = steps_a;
            dir_s       = dir_a;
          end
          // Counting down from zero wraps, so the target is the two's complement.
          term_s  = dir_s ? steps_sel_s : ({WIDTH{1'b0}} - steps_sel_s);
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        if (owner_req_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!owner_req_s) begin
          state_s = IDLE;
        end else if (at_term_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, owner, latched run parameters and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      owner_r <= OWN_A;
      last_r  <= OWN_B;
      dir_r   <= 1'b0;
      term_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      dir_r   <= dir_s;
      term_r  <= term_s;
      if ((state_r == IDLE) && (state_s == CLEAR)) begin
        last_r <= owner_s;
      end
    end
  end

  // Registered outputs decoded from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_a_r   <= 1'b0;
      gnt_b_r   <= 1'b0;
      done_a_r  <= 1'b0;
      done_b_r  <= 1'b0;
      busy_r    <= 1'b0;
      cnt_rst_r <= 1'b0;
      cnt_dir_r <= 1'b0;
    end else begin
      gnt_a_r   <= (state_s != IDLE) && (owner_s == OWN_A);
      gnt_b_r   <= (state_s != IDLE) && (owner_s == OWN_B);
      done_a_r  <= (state_s == DONE) && (owner_s == OWN_A);
      done_b_r  <= (state_s == DONE) && (owner_s == OWN_B);
      busy_r    <= (state_s != IDLE);
      // Dedicated flop: cnt_rst drives an async reset and must not glitch.
      cnt_rst_r <= (state_s == CLEAR);
      if ((state_r == CLEAR) && (state_s == RUN)) begin
        cnt_dir_r <= dir_r;
      end
    end
  end

  // Enable drops in the same cycle the target is reached or the owner aborts.
  assign cnt_enable    = (state_r == RUN) && owner_req_s && !at_term_s;
  assign cnt_direction = cnt_dir_r;
  assign cnt_rst       = cnt_rst_r;
  assign gnt_a         = gnt_a_r;
  assign gnt_b         = gnt_b_r;
  assign done_a        = done_a_r;
  assign done_b        = done_b_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: models the shared counter, runs directed vectors,
// hand-written corner sequences and a randomized phase with a transaction model.
module tb_counter_sched;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, dir_a, req_b, dir_b;
  logic [WIDTH-1:0] steps_a, steps_b;
  logic             gnt_a, done_a, gnt_b, done_b;
  logic             cnt_rst, cnt_enable, cnt_direction, busy;
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_clr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  counter_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .steps_a(steps_a), .dir_a(dir_a), .gnt_a(gnt_a), .done_a(done_a),
    .req_b(req_b), .steps_b(steps_b), .dir_b(dir_b), .gnt_b(gnt_b), .done_b(done_b),
    .cnt_rst(cnt_rst), .cnt_enable(cnt_enable), .cnt_direction(cnt_direction),
    .cnt_value(cnt_value), .busy(busy)
  );

  // The shared 8-bit wrap-around counter, reset by system rst or cnt_rst.
  assign cnt_clr = rst | cnt_rst;
  always @(posedge clk or posedge cnt_clr) begin
    if (cnt_clr) cnt_value <= '0;
    else if (cnt_enable) cnt_value <= cnt_direction ? cnt_value + 8'd1 : cnt_value - 8'd1;
  end

  // Requester inputs as seen by the DUT on each rising edge.
  logic s_ra, s_rb, s_da, s_db;
  logic [WIDTH-1:0] s_sa, s_sb;
  always @(posedge clk) begin
    s_ra <= req_a; s_rb <= req_b; s_da <= dir_a; s_db <= dir_b;
    s_sa <= steps_a; s_sb <= steps_b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(name, busy, 0);
  endtask

  typedef struct {
    logic       use_b;
    logic [7:0] steps;
    logic       dir;
    int         exp_en;
    int         exp_final;
    int         exp_done_k;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int en_cnt, rst_cnt, done_k, dir_bad, excl, wrong_done, fin;
    @(negedge clk);
    if (v.use_b) begin req_b = 1'b1; steps_b = v.steps; dir_b = v.dir; end
    else begin req_a = 1'b1; steps_a = v.steps; dir_a = v.dir; end
    en_cnt = 0; rst_cnt = 0; done_k = -1; dir_bad = 0; excl = 0; wrong_done = 0; fin = -1;
    for (int k = 0; k < 400 && done_k < 0; k++) begin
      @(negedge clk);
      if (k == 0) chk($sformatf("vec%0d gnt", idx), v.use_b ? gnt_b : gnt_a, 1);
      if (cnt_rst) rst_cnt++;
      if (cnt_enable) begin
        en_cnt++;
        if (cnt_direction !== v.dir) dir_bad++;
      end
      if (gnt_a && gnt_b) excl++;
      if (v.use_b ? done_a : done_b) wrong_done++;
      if (v.use_b ? done_b : done_a) begin done_k = k; fin = int'(cnt_value); end
    end
    chk($sformatf("vec%0d done_k", idx), done_k, v.exp_done_k);
    chk($sformatf("vec%0d enables", idx), en_cnt, v.exp_en);
    chk($sformatf("vec%0d cnt_rst_cycles", idx), rst_cnt, 1);
    chk($sformatf("vec%0d final", idx), fin, v.exp_final);
    chk($sformatf("vec%0d dir_bad", idx), dir_bad, 0);
    chk($sformatf("vec%0d excl", idx), excl, 0);
    chk($sformatf("vec%0d wrong_done", idx), wrong_done, 0);
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d busy_after", idx), busy, 0);
    chk($sformatf("vec%0d done_single", idx), done_a | done_b, 0);
    chk($sformatf("vec%0d gnt_after", idx), gnt_a | gnt_b, 0);
  endtask

  // Randomized-phase model state
  logic mlast, active, exp_own, exp_dir, prev_busy;
  int   exp_n, exp_term, k_r, en_r, dbad_r, extra_r;

  initial begin
    int owners[$];
    logic prev_g;
    int excl, dcount;

    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    steps_a = '0; steps_b = '0; dir_a = 1'b0; dir_b = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset gnt_a", gnt_a, 0);
    chk("reset gnt_b", gnt_b, 0);
    chk("reset done", {done_a, done_b}, 0);
    chk("reset cnt_rst", cnt_rst, 0);
    chk("reset cnt_enable", cnt_enable, 0);
    chk("reset cnt_direction", cnt_direction, 0);
    chk("reset busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // {use_b, steps, dir, enables, final value, done cycle after E0}
    vecs[0] = '{1'b0, 8'd5,   1'b1, 5,   5,   7};
    vecs[1] = '{1'b1, 8'd3,   1'b0, 3,   253, 5};
    vecs[2] = '{1'b0, 8'd0,   1'b1, 0,   0,   2};
    vecs[3] = '{1'b1, 8'd0,   1'b0, 0,   0,   2};
    vecs[4] = '{1'b0, 8'd1,   1'b0, 1,   255, 3};
    vecs[5] = '{1'b0, 8'd255, 1'b1, 255, 255, 257};
    vecs[6] = '{1'b1, 8'd255, 1'b0, 255, 1,   257};
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Fairness: both requesters held high continuously.
    do_reset();
    @(negedge clk);
    req_a = 1'b1; steps_a = 8'd2; dir_a = 1'b1;
    req_b = 1'b1; steps_b = 8'd1; dir_b = 1'b0;
    prev_g = 1'b0; excl = 0;
    for (int k = 0; k < 100 && owners.size() < 4; k++) begin
      @(negedge clk);
      if (gnt_a && gnt_b) excl++;
      if ((gnt_a || gnt_b) && !prev_g) owners.push_back(gnt_b ? 1 : 0);
      prev_g = gnt_a | gnt_b;
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("fair count", owners.size(), 4);
    while (owners.size() < 4) owners.push_back(-1);
    chk("fair g0", owners[0], 0);
    chk("fair g1", owners[1], 1);
    chk("fair g2", owners[2], 0);
    chk("fair g3", owners[3], 1);
    chk("fair excl", excl, 0);
    wait_idle("fair idle");

    // Abort: A drops its request two cycles into RUN while B waits.
    do_reset();
    @(negedge clk);
    req_a = 1'b1; steps_a = 8'd10; dir_a = 1'b1;
    req_b = 1'b1; steps_b = 8'd2;  dir_b = 1'b1;
    @(negedge clk);
    chk("abort gnt_a", gnt_a, 1);
    @(negedge clk);
    @(negedge clk);
    chk("abort pre enable", cnt_enable, 1);
    req_a = 1'b0;
    #1;
    chk("abort enable low", cnt_enable, 0);
    @(negedge clk);
    chk("abort idle busy", busy, 0);
    chk("abort idle gnt", gnt_a | gnt_b, 0);
    chk("abort no done_a", done_a, 0);
    @(negedge clk);
    chk("abort gnt_b", gnt_b, 1);
    dcount = 0;
    for (int k = 0; k < 20 && !done_b; k++) begin
      @(negedge clk);
      if (done_a) dcount++;
    end
    chk("abort done_b", done_b, 1);
    chk("abort stray done_a", dcount, 0);
    req_b = 1'b0;
    wait_idle("abort idle");

    // Reset in the middle of a long run.
    do_reset();
    @(negedge clk);
    req_a = 1'b1; steps_a = 8'd100; dir_a = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst running", cnt_enable, 1);
    rst = 1'b1;
    #1;
    chk("midrst outputs", {gnt_a, gnt_b, done_a, done_b, cnt_rst, cnt_enable, cnt_direction, busy}, 0);
    chk("midrst cnt", cnt_value, 0);
    req_b = 1'b1; steps_b = 8'd1; dir_b = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst first gnt_a", gnt_a, 1);
    chk("midrst first gnt_b", gnt_b, 0);
    req_a = 1'b0; req_b = 1'b0;
    wait_idle("midrst idle");

    // Randomized phase against a transaction-level model.
    do_reset();
    mlast = 1'b1; active = 1'b0; prev_busy = 1'b0;
    k_r = 0; en_r = 0; dbad_r = 0; extra_r = 0; exp_n = 0; exp_term = 0;
    for (int cyc = 0; cyc < 3500; cyc++) begin
      @(negedge clk);
      if (!active) begin
        if (gnt_a || gnt_b) begin
          exp_own = (s_ra && s_rb) ? ~mlast : s_rb;
          chk("rnd prior idle", prev_busy, 0);
          chk("rnd requested", s_ra | s_rb, 1);
          chk("rnd owner", {gnt_a, gnt_b}, exp_own ? 2'b01 : 2'b10);
          chk("rnd cnt_rst", cnt_rst, 1);
          mlast = exp_own;
          exp_n = exp_own ? int'(s_sb) : int'(s_sa);
          exp_dir = exp_own ? s_db : s_da;
          exp_term = exp_dir ? exp_n : (256 - exp_n) % 256;
          active = 1'b1; k_r = 0; en_r = 0; dbad_r = 0; extra_r = 0;
        end else begin
          chk("rnd idle quiet", {busy, done_a, done_b, cnt_enable, cnt_rst}, 0);
        end
      end else begin
        k_r++;
        if (cnt_rst || !busy || (gnt_a && gnt_b) || (exp_own ? done_a : done_b)) extra_r++;
        if (cnt_enable) begin
          en_r++;
          if (cnt_direction !== exp_dir) dbad_r++;
        end
        if (exp_own ? done_b : done_a) begin
          chk("rnd done_k", k_r, exp_n + 2);
          chk("rnd enables", en_r, exp_n);
          chk("rnd final", cnt_value, exp_term);
          chk("rnd dir", dbad_r, 0);
          chk("rnd misc", extra_r, 0);
          active = 1'b0;
        end else if (k_r > exp_n + 8) begin
          chk("rnd timeout", k_r, exp_n + 2);
          active = 1'b0;
        end
      end
      prev_busy = busy;
      // Requester A
      if (!req_a) begin
        if (cyc < 3000 && $urandom_range(0, 2) == 0) begin
          req_a = 1'b1; steps_a = 8'($urandom_range(0, 12)); dir_a = 1'($urandom_range(0, 1));
        end
      end else if (done_a) begin
        if (cyc >= 3000 || $urandom_range(0, 1) == 0) req_a = 1'b0;
        else begin steps_a = 8'($urandom_range(0, 12)); dir_a = 1'($urandom_range(0, 1)); end
      end else if (gnt_a) begin
        steps_a = 8'($urandom_range(0, 255)); dir_a = 1'($urandom_range(0, 1));
      end
      // Requester B
      if (!req_b) begin
        if (cyc < 3000 && $urandom_range(0, 2) == 0) begin
          req_b = 1'b1; steps_b = 8'($urandom_range(0, 12)); dir_b = 1'($urandom_range(0, 1));
        end
      end else if (done_b) begin
        if (cyc >= 3000 || $urandom_range(0, 1) == 0) req_b = 1'b0;
        else begin steps_b = 8'($urandom_range(0, 12)); dir_b = 1'($urandom_range(0, 1)); end
      end else if (gnt_b) begin
        steps_b = 8'($urandom_range(0, 255)); dir_b = 1'($urandom_range(0, 1));
      end
    end
    chk("rnd drained", active, 0);
    chk("rnd final idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
